// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and types
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int IDX_W    = 5;
  localparam int NUM_REGS = 1 << IDX_W;

  typedef logic [IDX_W-1:0] reg_index_t;
  typedef logic [XLEN-1:0]  word_t;
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// rtl/regfile_write_arbiter_rr_arbiter.sv - one-hot request arbiter, round-robin by default
// RFARB_FIXED_PRIORITY_EN selects fixed lowest-index-wins priority and removes the pointer.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

`ifdef RFARB_FIXED_PRIORITY_EN
  // Isolate the lowest set request bit.
  assign o_grant = i_req & (~i_req + N'(1));
`else
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin : search
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    o_grant = '0;
    ptr_d   = ptr_q;
    // Scan starts one past the last winner so it becomes lowest priority.
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_q) + off) % N;
      if (!found && i_req[idx]) begin
        found        = 1'b1;
        o_grant[idx] = 1'b1;
        if (i_advance) ptr_d = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= PW'(N - 1);
    else        ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the register-file write port among writeback producers
// and tracks pending destinations for RAW/WAW hazard detection.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int IDX_W   = rf_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  input  logic [NUM_REQ*IDX_W-1:0] i_req_index,
  input  logic [NUM_REQ*XLEN-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]       o_req_ready,
  output logic                     o_write_enable,
  output logic [IDX_W-1:0]         o_write_index,
  output logic [XLEN-1:0]          o_write_data,
  input  logic                     i_issue_valid,
  input  logic [IDX_W-1:0]         i_issue_rd,
  input  logic [IDX_W-1:0]         i_query_rs1,
  input  logic [IDX_W-1:0]         i_query_rs2,
  input  logic [IDX_W-1:0]         i_query_rd,
  output logic                     o_hazard,
  output logic [2**IDX_W-1:0]      o_busy
);

  localparam int NREGS = 2**IDX_W;

  logic [NUM_REQ-1:0] grant;
  logic               handshake;
  logic [IDX_W-1:0]   sel_index;
  logic [XLEN-1:0]    sel_data;

  logic               we_q, we_d;
  logic [IDX_W-1:0]   windex_q, windex_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [NREGS-1:0]   busy_q, busy_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (i_rst_n),
    .i_req     (i_req_valid),
    .i_advance (handshake),
    .o_grant   (grant)
  );

  // Grant only ever covers valid requesters, so any grant bit is a handshake.
  assign handshake   = |grant;
  assign o_req_ready = grant;

  always_comb begin
    sel_index = '0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        sel_index = i_req_index[k*IDX_W +: IDX_W];
        sel_data  = i_req_data[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    we_d     = handshake;
    windex_d = handshake ? sel_index : windex_q;
    wdata_d  = handshake ? sel_data  : wdata_q;
    busy_d   = busy_q;
    // Clear first so a same-edge reservation of the same register survives.
    if (we_q) busy_d[windex_q] = 1'b0;
    if (i_issue_valid && (i_issue_rd != '0)) busy_d[i_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q     <= 1'b0;
      windex_q <= '0;
      wdata_q  <= '0;
      busy_q   <= '0;
    end else begin
      we_q     <= we_d;
      windex_q <= windex_d;
      wdata_q  <= wdata_d;
      busy_q   <= busy_d;
    end
  end

  assign o_write_enable = we_q;
  assign o_write_index  = windex_q;
  assign o_write_data   = wdata_q;
  assign o_busy         = busy_q;

  assign o_hazard = ((i_query_rs1 != '0) & busy_q[i_query_rs1])
                  | ((i_query_rs2 != '0) & busy_q[i_query_rs2])
                  | ((i_query_rd  != '0) & busy_q[i_query_rd]);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector table, reset corner case and randomized model check
module tb_regfile_write_arbiter;
  localparam int NR = 3;
  localparam int XL = 32;
  localparam int IW = 5;
  localparam int NV = 22;

`ifdef RFARB_FIXED_PRIORITY_EN
  localparam logic [2:0]  G_ALT = 3'b001;
  localparam logic [4:0]  W_ALT = 5'd3;
  localparam logic [31:0] D_ALT = 32'h33;
`else
  localparam logic [2:0]  G_ALT = 3'b010;
  localparam logic [4:0]  W_ALT = 5'd4;
  localparam logic [31:0] D_ALT = 32'h44;
`endif

  logic             clk = 1'b0;
  logic             i_rst_n;
  logic [NR-1:0]    i_req_valid;
  logic [NR*IW-1:0] i_req_index;
  logic [NR*XL-1:0] i_req_data;
  logic [NR-1:0]    o_req_ready;
  logic             o_write_enable;
  logic [IW-1:0]    o_write_index;
  logic [XL-1:0]    o_write_data;
  logic             i_issue_valid;
  logic [IW-1:0]    i_issue_rd;
  logic [IW-1:0]    i_query_rs1;
  logic [IW-1:0]    i_query_rs2;
  logic [IW-1:0]    i_query_rd;
  logic             o_hazard;
  logic [31:0]      o_busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NUM_REQ(NR), .XLEN(XL), .IDX_W(IW)) dut (
    .clk            (clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .i_req_index    (i_req_index),
    .i_req_data     (i_req_data),
    .o_req_ready    (o_req_ready),
    .o_write_enable (o_write_enable),
    .o_write_index  (o_write_index),
    .o_write_data   (o_write_data),
    .i_issue_valid  (i_issue_valid),
    .i_issue_rd     (i_issue_rd),
    .i_query_rs1    (i_query_rs1),
    .i_query_rs2    (i_query_rs2),
    .i_query_rd     (i_query_rd),
    .o_hazard       (o_hazard),
    .o_busy         (o_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  vld;
    logic [4:0]  i0, i1;
    logic [31:0] d0, d1;
    logic        iv;
    logic [4:0]  ird, rs1, rs2, rd;
    logic [2:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_widx;
    logic [31:0] e_wdata;
    logic        e_haz;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs[NV];

  // Reference model state: what the spec says the write port and scoreboard hold.
  logic [31:0] m_busy;
  int          m_last;
  logic        m_we;
  logic [4:0]  m_widx;
  logic [31:0] m_wdata;
  logic        pv[NR];
  logic [4:0]  pix[NR];
  logic [31:0] pdt[NR];

  task automatic drive_idle();
    i_req_valid   = '0;
    i_req_index   = '0;
    i_req_data    = '0;
    i_issue_valid = 1'b0;
    i_issue_rd    = '0;
    i_query_rs1   = '0;
    i_query_rs2   = '0;
    i_query_rd    = '0;
  endtask

  task automatic model_reset();
    m_busy  = '0;
    m_last  = NR - 1;
    m_we    = 1'b0;
    m_widx  = '0;
    m_wdata = '0;
    for (int k = 0; k < NR; k++) begin
      pv[k]  = 1'b0;
      pix[k] = '0;
      pdt[k] = '0;
    end
  endtask

  // Winner is the valid requester closest after the last winner in circular order.
  function automatic int model_grant();
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = NR + 1;
    for (int k = 0; k < NR; k++) begin
      if (pv[k]) begin
`ifdef RFARB_FIXED_PRIORITY_EN
        d = k;
`else
        d = (k - m_last - 1 + 2 * NR) % NR;
`endif
        if (d < bestd) begin
          bestd = d;
          best  = k;
        end
      end
    end
    return best;
  endfunction

  function automatic logic model_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    return (a != 0 && m_busy[a]) || (b != 0 && m_busy[b]) || (c != 0 && m_busy[c]);
  endfunction

  initial begin
    //             vld i0 i1 d0            d1     iv ird rs1 rs2 rd  rdy    we widx   wdata         haz busy
    vecs[0]  = '{3'b001, 5, 0, 32'hDEADBEEF, 0,     0, 0,  0,  0,  0, 3'b001, 0, 0,     0,            0, 0};
    vecs[1]  = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  0,  0, 3'b000, 1, 5,     32'hDEADBEEF, 0, 0};
    vecs[2]  = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  0,  0, 3'b000, 0, 5,     32'hDEADBEEF, 0, 0};
    vecs[3]  = '{3'b011, 3, 4, 32'h33,       32'h44, 0, 0, 0,  0,  0, G_ALT,  0, 5,     32'hDEADBEEF, 0, 0};
    vecs[4]  = '{3'b011, 3, 4, 32'h33,       32'h44, 0, 0, 0,  0,  0, 3'b001, 1, W_ALT, D_ALT,        0, 0};
    vecs[5]  = '{3'b011, 3, 4, 32'h33,       32'h44, 0, 0, 0,  0,  0, G_ALT,  1, 3,     32'h33,       0, 0};
    vecs[6]  = '{3'b011, 3, 4, 32'h33,       32'h44, 0, 0, 0,  0,  0, 3'b001, 1, W_ALT, D_ALT,        0, 0};
    vecs[7]  = '{3'b000, 0, 0, 0,            0,     1, 7,  7,  0,  0, 3'b000, 1, 3,     32'h33,       0, 0};
    vecs[8]  = '{3'b000, 0, 0, 0,            0,     0, 0,  7,  0,  0, 3'b000, 0, 3,     32'h33,       1, 32'h80};
    vecs[9]  = '{3'b001, 7, 0, 32'h77,       0,     0, 0,  7,  0,  0, 3'b001, 0, 3,     32'h33,       1, 32'h80};
    vecs[10] = '{3'b000, 0, 0, 0,            0,     0, 0,  7,  0,  0, 3'b000, 1, 7,     32'h77,       1, 32'h80};
    vecs[11] = '{3'b000, 0, 0, 0,            0,     0, 0,  7,  0,  0, 3'b000, 0, 7,     32'h77,       0, 0};
    vecs[12] = '{3'b001, 9, 0, 32'h99,       0,     0, 0,  0,  0,  0, 3'b001, 0, 7,     32'h77,       0, 0};
    vecs[13] = '{3'b000, 0, 0, 0,            0,     1, 9,  0,  9,  0, 3'b000, 1, 9,     32'h99,       0, 0};
    vecs[14] = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  9,  0, 3'b000, 0, 9,     32'h99,       1, 32'h200};
    vecs[15] = '{3'b001, 9, 0, 32'h9A,       0,     0, 0,  0,  9,  0, 3'b001, 0, 9,     32'h99,       1, 32'h200};
    vecs[16] = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  9,  0, 3'b000, 1, 9,     32'h9A,       1, 32'h200};
    vecs[17] = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  9,  0, 3'b000, 0, 9,     32'h9A,       0, 0};
    vecs[18] = '{3'b001, 0, 0, 32'h1234,     0,     1, 0,  0,  0,  0, 3'b001, 0, 9,     32'h9A,       0, 0};
    vecs[19] = '{3'b000, 0, 0, 0,            0,     0, 0,  0,  0,  0, 3'b000, 1, 0,     32'h1234,     0, 0};
    vecs[20] = '{3'b001, 2, 0, 32'h22,       0,     1, 7,  0,  0,  0, 3'b001, 0, 0,     32'h1234,     0, 0};
    vecs[21] = '{3'b001, 12, 0, 32'hCC,      0,     1, 11, 0,  0,  7, 3'b001, 1, 2,     32'h22,       1, 32'h80};

    i_rst_n = 1'b0;
    drive_idle();
    #12;
    chk("rst_we", o_write_enable, 0);
    chk("rst_widx", o_write_index, 0);
    chk("rst_wdata", o_write_data, 0);
    chk("rst_busy", o_busy, 0);
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk) #1;

    for (int r = 0; r < NV; r++) begin
      i_req_valid   = vecs[r].vld;
      i_req_index   = {5'd0, vecs[r].i1, vecs[r].i0};
      i_req_data    = {32'd0, vecs[r].d1, vecs[r].d0};
      i_issue_valid = vecs[r].iv;
      i_issue_rd    = vecs[r].ird;
      i_query_rs1   = vecs[r].rs1;
      i_query_rs2   = vecs[r].rs2;
      i_query_rd    = vecs[r].rd;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", r),   o_req_ready,    vecs[r].e_rdy);
      chk($sformatf("v%0d_we", r),    o_write_enable, vecs[r].e_we);
      chk($sformatf("v%0d_widx", r),  o_write_index,  vecs[r].e_widx);
      chk($sformatf("v%0d_wdata", r), o_write_data,   vecs[r].e_wdata);
      chk($sformatf("v%0d_haz", r),   o_hazard,       vecs[r].e_haz);
      chk($sformatf("v%0d_busy", r),  o_busy,         vecs[r].e_busy);
      @(posedge clk) #1;
    end

    // Reset asserted mid-cycle while a write is in flight and registers are reserved.
    drive_idle();
    @(negedge clk);
    chk("mid_pre_we", o_write_enable, 1);
    chk("mid_pre_widx", o_write_index, 12);
    chk("mid_pre_busy", o_busy, 32'h880);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_we", o_write_enable, 0);
    chk("mid_busy", o_busy, 0);
    chk("mid_widx", o_write_index, 0);
    chk("mid_wdata", o_write_data, 0);
    @(negedge clk);
    i_rst_n     = 1'b1;
    i_req_valid = 3'b011;
    i_req_index = {5'd0, 5'd2, 5'd1};
    #1;
    chk("mid_first_grant", o_req_ready, 3'b001);
    @(posedge clk) #1;

    drive_idle();
    i_rst_n = 1'b0;
    model_reset();
    @(negedge clk) i_rst_n = 1'b1;
    @(posedge clk) #1;

    for (int c = 0; c < 400; c++) begin
      int          g;
      logic [31:0] nb;
      for (int k = 0; k < NR; k++) begin
        if (!pv[k]) begin
          pv[k]  = 1'($urandom_range(0, 1));
          pix[k] = 5'($urandom_range(0, 7));
          pdt[k] = $urandom;
        end
        i_req_valid[k]           = pv[k];
        i_req_index[k*IW +: IW]  = pix[k];
        i_req_data[k*XL +: XL]   = pdt[k];
      end
      i_issue_valid = ($urandom_range(0, 2) == 0);
      i_issue_rd    = 5'($urandom_range(0, 7));
      i_query_rs1   = 5'($urandom_range(0, 7));
      i_query_rs2   = 5'($urandom_range(0, 7));
      i_query_rd    = 5'($urandom_range(0, 7));
      @(negedge clk);
      g = model_grant();
      chk($sformatf("r%0d_rdy", c), o_req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
      chk($sformatf("r%0d_we", c), o_write_enable, m_we);
      chk($sformatf("r%0d_widx", c), o_write_index, m_widx);
      chk($sformatf("r%0d_wdata", c), o_write_data, m_wdata);
      chk($sformatf("r%0d_haz", c), o_hazard, model_hazard(i_query_rs1, i_query_rs2, i_query_rd));
      chk($sformatf("r%0d_busy", c), o_busy, m_busy);
      nb = m_busy;
      if (m_we) nb[m_widx] = 1'b0;
      if (i_issue_valid && i_issue_rd != 0) nb[i_issue_rd] = 1'b1;
      m_busy = nb;
      if (g >= 0) begin
        m_last  = g;
        m_we    = 1'b1;
        m_widx  = pix[g];
        m_wdata = pdt[g];
        pv[g]   = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      @(posedge clk) #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port among NUM_REQ writeback producers (e.g. ALU writeback, load return) using valid/ready handshakes and round-robin grant.
- Drives the register file write port from a registered output stage.
- Keeps a scoreboard of registers with an issued but uncommitted write, and flags RAW/WAW hazards to the issue stage.
- Sits between the execute/memory writeback paths and the register file.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4)
XLEN, 32, data width
IDX_W, 5, register index width

Ports:
clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req_valid  in  NUM_REQ  per-requester write request
i_req_index  in  NUM_REQ*IDX_W  destination index, requester k at bits [k*IDX_W +: IDX_W]
i_req_data  in  NUM_REQ*XLEN  write data, requester k at bits [k*XLEN +: XLEN]
o_req_ready  out  NUM_REQ  grant; handshake = valid & ready
o_write_enable  out  1  to register file
o_write_index  out  IDX_W  to register file
o_write_data  out  XLEN  to register file
i_issue_valid  in  1  issue stage reserves a destination
i_issue_rd  in  IDX_W  destination being reserved
i_query_rs1  in  IDX_W  source 1 of instruction in issue
i_query_rs2  in  IDX_W  source 2 of instruction in issue
i_query_rd  in  IDX_W  destination of instruction in issue
o_hazard  out  1  issue must stall
o_busy  out  2**IDX_W  scoreboard bitmap

Behaviour:
- Reset (async assert, sync release): o_write_enable=0, o_write_index=0, o_write_data=0, o_busy=0, RR pointer=NUM_REQ-1 (requester 0 wins first).
- Grant is combinational:
  - Exactly one o_req_ready bit high when any valid; none when no valid.
  - Ready never asserts without valid.
  - Priority starts at (pointer+1) mod NUM_REQ.
  - Pointer updates to the granted index at a handshake edge; otherwise holds.
- Requesters hold valid/index/data stable until handshake. Valid must not depend on ready.
- Output stage:
  - At a handshake edge, index/data are registered and o_write_enable=1 for exactly the next cycle. Latency handshake->write port = 1 cycle.
  - No handshake: o_write_enable=0; index/data hold their last values.
  - Throughput is 1 write/cycle.
- Index 0: request still handshakes and is forwarded to the write port (the register file ignores it). Scoreboard bit 0 is never set.
- Scoreboard set: at an edge with i_issue_valid=1 and i_issue_rd!=0, busy[i_issue_rd]<=1.
- Scoreboard clear: at an edge with o_write_enable=1, busy[o_write_index]<=0. Clearing at the commit edge guarantees the register file holds the data afterwards.
- Set and clear on the same index at the same edge: set wins (newer producer).
- o_hazard = busy[rs1] | busy[rs2] | busy[rd], with each term masked to 0 for index 0.
  - Combinational, from the registered busy only (no forwarding).
  - The issue stage must not assert i_issue_valid while o_hazard=1. If it does, the set is still applied (no error flag).
- Writeback to a non-busy register: no scoreboard change.
- Reset mid-operation: any in-flight output-stage write is dropped and all busy bits are cleared. Requesters must re-present.

Optional Feature:
- Macro RFARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest requester index wins. The RR pointer is removed, and a continuously valid requester 0 starves the others.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package rf_pkg holds:
  - constants XLEN=32, IDX_W=5, NUM_REGS=32
  - typedefs reg_index_t (logic [IDX_W-1:0]) and word_t (logic [XLEN-1:0])
- The register file and this block both import rf_pkg.
- One sub-module, rr_arbiter:
  - parameter N
  - inputs i_req[N] and i_advance
  - output o_grant one-hot
  - owns the pointer and the RFARB_FIXED_PRIORITY_EN variant

Test Plan:
- After reset, req0 valid idx=5 data=0xDEADBEEF -> ready[0] same cycle; next cycle o_write_enable=1, idx=5, data=0xDEADBEEF; the cycle after, o_write_enable=0.
- req0 and req1 valid continuously (idx 3/4) -> grants alternate 0,1,0,1; write port shows 3,4,3,4 back-to-back. With RFARB_FIXED_PRIORITY_EN -> 0,0,0,0.
- Issue rd=7; query rs1=7 -> o_hazard=1. Writeback idx 7 handshakes at edge N -> o_hazard still 1 in cycle N+1, 0 in N+2; o_busy[7]=0.
- Issue rd=9 at the same edge as the commit of idx 9 -> o_busy[9]=1 afterwards.
- Issue rd=0 and writeback idx=0 -> o_busy stays 0; queries on x0 give o_hazard=0; write port shows idx 0 with enable=1.
- Assert i_rst_n=0 mid-cycle while o_write_enable=1 and busy=0x0000_0880 -> o_write_enable=0 and o_busy=0 immediately; first grant after release goes to req0.
